reorder_buffer: RTL and testbench

Circular 8-entry reorder buffer for the Tomasulo core. It allocates a destination tag to each instruction at issue and captures results broadcast on the CDB. It retires entries in program order onto the commit bus that writes the architectural register file. It also answers operand-tag lookups so issue can read completed-but-uncommitted values.

---
 rtl/tomasulo_types.sv | 41 ++++
 rtl/rob_lookup.sv | 48 ++++
 rtl/reorder_buffer.sv | 172 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_types.sv
// Shared Tomasulo core types: ROB entry, CDB broadcast, commit bus and
// tag helpers. Imported by the reorder buffer and its lookup port.
package tomasulo_types;

    localparam int XLEN = 32;

    // A tag with bit 3 set means "no producer".
    localparam logic [3:0] TAG_INVALID = 4'b1000;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } rob_entry_t;

    typedef struct packed {
        logic            valid;
        logic [3:0]      tag;
        logic [XLEN-1:0] data;
    } cdb_t;

    // Bus consumed unconditionally by the architectural register file.
    typedef struct packed {
        logic            valid;
        logic [3:0]      tag;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } commit_t;

    // True when the tag names a real entry of a ROB with 'depth' slots.
    function automatic logic tag_in_range(input logic [3:0] tag, input int depth);
        return (tag[3] == 1'b0) && (int'(tag[2:0]) < depth);
    endfunction

    // Advance a 3-bit ring pointer, wrapping at depth.
    function automatic logic [2:0] ptr_inc(input logic [2:0] ptr, input int depth);
        return (int'(ptr) == depth - 1) ? 3'd0 : ptr + 3'd1;
    endfunction

endpackage

// File: rtl/rob_lookup.sv
// Operand-tag lookup port of the reorder buffer. Returns ready/data for a
// completed-but-uncommitted producer.
// Optional macro ROB_CDB_BYPASS_EN: also forward a same-cycle CDB broadcast.
module rob_lookup
    import tomasulo_types::*;
#(
    parameter int DEPTH = 8
) (
    input  logic [3:0]                  tag_i,
    input  rob_entry_t [DEPTH-1:0]      entries_i,
    input  cdb_t                        cdb_i,
    output logic                        rdy_o,
    output logic [XLEN-1:0]             data_o
);

    logic       tag_ok;
    rob_entry_t sel;

    assign tag_ok = tag_in_range(tag_i, DEPTH);
    assign sel    = entries_i[tag_i[2:0]];

    // Registered entry state first; the optional bypass overrides it.
    always_comb begin
        rdy_o  = 1'b0;
        data_o = '0;
        if (tag_ok && sel.busy) begin
            rdy_o  = sel.done;
            data_o = sel.data;
        end
`ifdef ROB_CDB_BYPASS_EN
        if (tag_ok && sel.busy && cdb_i.valid && (cdb_i.tag == tag_i)) begin
            rdy_o  = 1'b1;
            data_o = cdb_i.data;
        end
`endif
    end

    // The destination register is irrelevant to operand forwarding.
    logic unused_rd;
    assign unused_rd = ^sel.rd;

`ifndef ROB_CDB_BYPASS_EN
    // Without bypass the broadcast is only seen once it is registered.
    logic unused_cdb;
    assign unused_cdb = ^cdb_i;
`endif

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer for the Tomasulo core: allocates tags at issue,
// captures CDB results, retires in program order and serves operand lookups.
// Optional macro ROB_CDB_BYPASS_EN (in rob_lookup): same-cycle CDB forwarding.
// WIDTH must equal tomasulo_types::XLEN; DEPTH must be a power of two <= 8.
module reorder_buffer
    import tomasulo_types::*;
#(
    parameter int         DEPTH       = 8,
    parameter int         WIDTH       = 32,
    parameter logic [3:0] TAG_INVALID = tomasulo_types::TAG_INVALID
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    output logic             alloc_ready,
    output logic [3:0]       alloc_tag,
    input  logic             cdb_valid,
    input  logic [3:0]       cdb_tag,
    input  logic [WIDTH-1:0] cdb_data,
    input  logic [3:0]       rs1_tag,
    input  logic [3:0]       rs2_tag,
    output logic             rs1_rdy,
    output logic             rs2_rdy,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data,
    output logic             commit_valid,
    output logic [3:0]       commit_tag,
    output logic [4:0]       commit_rd,
    output logic [WIDTH-1:0] commit_data
);

    logic [2:0] head_q, head_d;
    logic [2:0] tail_q, tail_d;
    logic [3:0] count_q, count_d;

    rob_entry_t [DEPTH-1:0] entries;
    rob_entry_t             head_entry;
    cdb_t                   cdb_bus;
    commit_t                commit_bus;

    logic       alloc_fire;
    logic       commit_fire;
    logic       cdb_hit;
    logic [2:0] cdb_idx;

    // Readiness looks only at registered occupancy, so a full ROB refuses
    // alloc even in a cycle where it is committing.
    assign alloc_ready = (count_q != 4'(DEPTH));
    assign alloc_tag   = {1'b0, tail_q};
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;

    assign cdb_bus.valid = cdb_valid;
    assign cdb_bus.tag   = cdb_tag;
    assign cdb_bus.data  = cdb_data;

    // A broadcast lands only on a busy entry named by a valid tag.
    assign cdb_idx = cdb_tag[2:0];
    assign cdb_hit = cdb_valid && (cdb_tag != TAG_INVALID) && tag_in_range(cdb_tag, DEPTH)
                     && entries[cdb_idx].busy;

    assign head_entry       = entries[head_q];
    assign commit_bus.valid = head_entry.busy && head_entry.done && !flush;
    assign commit_bus.tag   = {1'b0, head_q};
    assign commit_bus.rd    = commit_bus.valid ? head_entry.rd : 5'd0;
    assign commit_bus.data  = commit_bus.valid ? head_entry.data : '0;
    assign commit_fire      = commit_bus.valid;

    assign commit_valid = commit_bus.valid;
    assign commit_tag   = commit_bus.tag;
    assign commit_rd    = commit_bus.rd;
    assign commit_data  = commit_bus.data;

    // Per-entry state: flush wipes busy/done, otherwise CDB, commit and alloc
    // touch disjoint entries because a full ROB blocks alloc.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        rob_entry_t ent_q, ent_d;

        // Next-state for this entry.
        always_comb begin
            ent_d = ent_q;
            if (flush) begin
                ent_d.busy = 1'b0;
                ent_d.done = 1'b0;
            end else begin
                if (cdb_hit && (cdb_idx == 3'(gi))) begin
                    ent_d.data = cdb_data;
                    ent_d.done = 1'b1;
                end
                if (commit_fire && (head_q == 3'(gi))) begin
                    ent_d.busy = 1'b0;
                    ent_d.done = 1'b0;
                end
                if (alloc_fire && (tail_q == 3'(gi))) begin
                    ent_d.busy = 1'b1;
                    ent_d.done = 1'b0;
                    ent_d.rd   = alloc_rd;
                end
            end
        end

        // Entry register; reset clears every field.
        always_ff @(posedge clk) begin
            if (rst) begin
                ent_q <= '0;
            end else begin
                ent_q <= ent_d;
            end
        end

        assign entries[gi] = ent_q;
    end

    // Pointer and occupancy next-state; flush returns the ring to empty.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = 3'd0;
            tail_d  = 3'd0;
            count_d = 4'd0;
        end else begin
            if (alloc_fire) begin
                tail_d = ptr_inc(tail_q, DEPTH);
            end
            if (commit_fire) begin
                head_d = ptr_inc(head_q, DEPTH);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + 4'd1;
                2'b01:   count_d = count_q - 4'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= 3'd0;
            tail_q  <= 3'd0;
            count_q <= 4'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    rob_lookup #(
        .DEPTH(DEPTH)
    ) u_lookup_rs1 (
        .tag_i     (rs1_tag),
        .entries_i (entries),
        .cdb_i     (cdb_bus),
        .rdy_o     (rs1_rdy),
        .data_o    (rs1_data)
    );

    rob_lookup #(
        .DEPTH(DEPTH)
    ) u_lookup_rs2 (
        .tag_i     (rs2_tag),
        .entries_i (entries),
        .cdb_i     (cdb_bus),
        .rdy_o     (rs2_rdy),
        .data_o    (rs2_data)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: allocations push expected commits,
// a negedge monitor pops and compares each retiring entry.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_rd = 5'd0;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_tag = 4'd0;
    logic [31:0] cdb_data = 32'd0;
    logic [3:0]  rs1_tag = 4'd0;
    logic [3:0]  rs2_tag = 4'd0;
    logic        rs1_rdy, rs2_rdy;
    logic [31:0] rs1_data, rs2_data;
    logic        commit_valid;
    logic [3:0]  commit_tag;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;

    typedef struct {
        logic [3:0] tag;
        logic [4:0] rd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_data [8];
    int          vectors = 0;
    int          miscompares = 0;
    int          commits = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_rd     (alloc_rd),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .rs1_tag      (rs1_tag),
        .rs2_tag      (rs2_tag),
        .rs1_rdy      (rs1_rdy),
        .rs2_rdy      (rs2_rdy),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .commit_valid (commit_valid),
        .commit_tag   (commit_tag),
        .commit_rd    (commit_rd),
        .commit_data  (commit_data)
    );

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic [3:0] exp_tag);
        exp_t e;
        check_val("alloc_ready", {63'd0, alloc_ready}, 64'd1);
        check_val("alloc_tag", {60'd0, alloc_tag}, {60'd0, exp_tag});
        e.tag = exp_tag;
        e.rd  = rd;
        sb.push_back(e);
        alloc_valid = 1'b1;
        alloc_rd    = rd;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic cdb_send(input logic [3:0] t, input logic [31:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = d;
        tick();
        cdb_valid = 1'b0;
    endtask

    // Commit monitor: every retiring entry must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && commit_valid === 1'b1) begin
            commits++;
            $display("commit tag %0d rd %0d data 0x%08h", commit_tag, commit_rd, commit_data);
            if (sb.size() == 0) begin
                check_val("commit_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_val("commit_tag", {60'd0, commit_tag}, {60'd0, e.tag});
                check_val("commit_rd", {59'd0, commit_rd}, {59'd0, e.rd});
                check_val("commit_data", {32'd0, commit_data}, {32'd0, model_data[e.tag]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  exp_tail;
        exp_t        e;
        for (int i = 0; i < 8; i++) model_data[i] = 32'd0;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        check_val("rst_alloc_ready", {63'd0, alloc_ready}, 64'd1);
        check_val("rst_alloc_tag", {60'd0, alloc_tag}, 64'd0);
        check_val("rst_commit_valid", {63'd0, commit_valid}, 64'd0);
        check_val("rst_commit_tag", {60'd0, commit_tag}, 64'd0);
        check_val("rst_commit_rd", {59'd0, commit_rd}, 64'd0);
        check_val("rst_commit_data", {32'd0, commit_data}, 64'd0);
        check_val("rst_rs1_rdy", {63'd0, rs1_rdy}, 64'd0);
        check_val("rst_rs2_data", {32'd0, rs2_data}, 64'd0);

        // Fill: tags 0..7 in order, then full
        for (int i = 0; i < 8; i++) do_alloc(5'(i + 1), 4'(i));
        check_val("full_ready", {63'd0, alloc_ready}, 64'd0);
        alloc_valid = 1'b1;
        alloc_rd    = 5'd9;
        tick();
        alloc_valid = 1'b0;
        check_val("ninth_ready", {63'd0, alloc_ready}, 64'd0);
        check_val("ninth_tag", {60'd0, alloc_tag}, 64'd0);

        // Out-of-order completion does not commit
        model_data[2] = 32'h0000_DEAD;
        cdb_send(4'd2, 32'h0000_DEAD);
        check_val("no_commit_tag2", {63'd0, commit_valid}, 64'd0);

        // Lookup of tag 3 in broadcast cycle and afterwards
        rs1_tag       = 4'd3;
        model_data[3] = 32'h55;
        cdb_valid = 1'b1;
        cdb_tag   = 4'd3;
        cdb_data  = 32'h55;
        #1;
`ifdef ROB_CDB_BYPASS_EN
        check_val("bypass_rdy", {63'd0, rs1_rdy}, 64'd1);
        check_val("bypass_data", {32'd0, rs1_data}, 64'h55);
`else
        check_val("bypass_rdy", {63'd0, rs1_rdy}, 64'd0);
        check_val("bypass_data", {32'd0, rs1_data}, 64'd0);
`endif
        tick();
        cdb_valid = 1'b0;
        #1;
        check_val("lookup_rdy", {63'd0, rs1_rdy}, 64'd1);
        check_val("lookup_data", {32'd0, rs1_data}, 64'h55);

        // Head completes: commit next cycle, full ROB still refuses alloc
        model_data[0] = 32'h11;
        cdb_send(4'd0, 32'h11);
        check_val("head_commit_valid", {63'd0, commit_valid}, 64'd1);
        check_val("commit_cycle_ready", {63'd0, alloc_ready}, 64'd0);
        tick();
        check_val("tag1_stall", {63'd0, commit_valid}, 64'd0);
        do_alloc(5'd9, 4'd0);
        repeat (3) begin
            tick();
            check_val("tag1_stall", {63'd0, commit_valid}, 64'd0);
        end
        model_data[1] = 32'h22;
        cdb_send(4'd1, 32'h22);
        tick();
        tick();
        tick();
        check_val("tag4_stall", {63'd0, commit_valid}, 64'd0);

        // Dropped broadcasts: non-busy entry and invalid tag
        cdb_send(4'd1, 32'h99);
        rs1_tag = 4'd1;
        #1;
        check_val("nonbusy_rdy", {63'd0, rs1_rdy}, 64'd0);
        check_val("nonbusy_data", {32'd0, rs1_data}, 64'd0);
        check_val("nonbusy_commit", {63'd0, commit_valid}, 64'd0);
        cdb_send(4'b1000, 32'h77);
        rs2_tag = 4'd0;
        #1;
        check_val("invtag_entry0_rdy", {63'd0, rs2_rdy}, 64'd0);
        rs2_tag = 4'b1000;
        #1;
        check_val("invtag_rdy", {63'd0, rs2_rdy}, 64'd0);
        check_val("invtag_data", {32'd0, rs2_data}, 64'd0);
        check_val("invtag_commit", {63'd0, commit_valid}, 64'd0);

        // Five live entries (4,5,6,7,0), two done, then flush
        model_data[5] = 32'h5;
        cdb_send(4'd5, 32'h5);
        model_data[7] = 32'h7;
        cdb_send(4'd7, 32'h7);
        rs1_tag = 4'd5;
        #1;
        check_val("pre_flush_rdy5", {63'd0, rs1_rdy}, 64'd1);
        flush       = 1'b1;
        alloc_valid = 1'b1;
        alloc_rd    = 5'd3;
        cdb_valid   = 1'b1;
        cdb_tag     = 4'd4;
        cdb_data    = 32'h44;
        #1;
        check_val("flush_commit_valid", {63'd0, commit_valid}, 64'd0);
        tick();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        cdb_valid   = 1'b0;
        sb.delete();
        rs2_tag = 4'd7;
        #1;
        check_val("flush_alloc_tag", {60'd0, alloc_tag}, 64'd0);
        check_val("flush_ready", {63'd0, alloc_ready}, 64'd1);
        check_val("flush_commit", {63'd0, commit_valid}, 64'd0);
        check_val("flush_rs1_rdy", {63'd0, rs1_rdy}, 64'd0);
        check_val("flush_rs2_rdy", {63'd0, rs2_rdy}, 64'd0);
        rs1_tag = 4'd4;
        #1;
        check_val("flush_cdb_dropped", {63'd0, rs1_rdy}, 64'd0);

        // Count really is 0: exactly eight allocs fit again
        for (int i = 0; i < 8; i++) do_alloc(5'(10 + i), 4'(i));
        check_val("refill_full", {63'd0, alloc_ready}, 64'd0);

        // Streaming: complete in order while allocating behind the commits
        exp_tail = 4'd0;
        for (int i = 0; i < 8; i++) begin
            d             = $urandom;
            model_data[i] = d;
            cdb_valid = 1'b1;
            cdb_tag   = 4'(i);
            cdb_data  = d;
            if (i == 1) begin
                check_val("stream_full_commit", {63'd0, commit_valid}, 64'd1);
                check_val("stream_full_ready", {63'd0, alloc_ready}, 64'd0);
            end
            if (i >= 2) begin
                check_val("stream_ready", {63'd0, alloc_ready}, 64'd1);
                check_val("stream_tag", {60'd0, alloc_tag}, {60'd0, exp_tail});
                e.tag = exp_tail;
                e.rd  = 5'(20 + i);
                sb.push_back(e);
                alloc_valid = 1'b1;
                alloc_rd    = 5'(20 + i);
                exp_tail    = exp_tail + 4'd1;
            end
            tick();
            alloc_valid = 1'b0;
            cdb_valid   = 1'b0;
        end
        for (int j = 0; j < 6; j++) begin
            d             = $urandom;
            model_data[j] = d;
            cdb_send(4'(j), d);
        end
        repeat (4) tick();

        check_val("sb_empty", 64'(sb.size()), 64'd0);
        check_val("commit_count", 64'(commits), 64'd18);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
